// File: rtl/burst_read_buffer_if.sv
// Handshake and data bundle between a DRAM read port, the line buffer and its consumer.
// The slave modport is the buffer side; the master modport is the DRAM/consumer side.
interface burst_read_buffer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                     WE;
  logic [WIDTH-1:0]         dIn;
  logic                     START;
  logic                     LINE_ACK;
  logic [WIDTH*DEPTH-1:0]   dOut;
  logic                     LINE_VALID;
  logic [CW-1:0]            COUNT;
  logic                     BUSY;
  logic                     OVERFLOW;

  modport slave (
    input  WE, dIn, START, LINE_ACK,
    output dOut, LINE_VALID, COUNT, BUSY, OVERFLOW
  );

  modport master (
    output WE, dIn, START, LINE_ACK,
    input  dOut, LINE_VALID, COUNT, BUSY, OVERFLOW
  );
endinterface

// File: rtl/burst_read_buffer.sv
// Collects a burst of DEPTH DRAM words into one line through a shift chain (first word lands
// in slot 0) and holds it for a consumer, flagging words that arrive while the line is full.
module burst_read_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input logic               DRAMCLK,
  input logic               RESET,
  burst_read_buffer_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StFill, StFull} state_e;

  state_e                      state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0] line_q;
  logic [CW-1:0]               count_q, count_d;
  logic                        overflow_q, overflow_d;
  logic                        shift;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    shift      = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.START) begin
          state_d    = StFill;
          count_d    = '0;
          overflow_d = 1'b0;
          if (bus.WE) begin
            shift   = 1'b1;
            count_d = CW'(1);
          end
        end
      end
      StFill: begin
        if (bus.START) begin
          count_d    = '0;
          overflow_d = 1'b0;
          if (bus.WE) begin
            shift   = 1'b1;
            count_d = CW'(1);
          end
        end else if (bus.WE) begin
          shift   = 1'b1;
          count_d = count_q + CW'(1);
          if (count_q == CW'(DEPTH - 1)) state_d = StFull;
        end
      end
      StFull: begin
        // START only counts here when paired with LINE_ACK; alone it must not drop the line.
        if (bus.START && bus.LINE_ACK) begin
          state_d    = StFill;
          count_d    = '0;
          overflow_d = 1'b0;
          if (bus.WE) begin
            shift   = 1'b1;
            count_d = CW'(1);
          end
        end else begin
          if (bus.LINE_ACK) begin
            state_d = StIdle;
            count_d = '0;
          end
          if (bus.WE) overflow_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge DRAMCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StIdle;
      line_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (shift) line_q <= {bus.dIn, line_q[DEPTH-1:1]};
    end
  end

  assign bus.dOut       = line_q;
  assign bus.COUNT      = count_q;
  assign bus.BUSY       = (state_q == StFill);
  assign bus.LINE_VALID = (state_q == StFull);
  assign bus.OVERFLOW   = overflow_q;
endmodule

// File: tb/tb_burst_read_buffer.sv
// Self-checking bench for burst_read_buffer: scoreboard of captured words checked against
// the assembled line, plus overflow, back-to-back, restart, async reset and size sweep.
module tb_burst_read_buffer;
  logic DRAMCLK = 1'b0;
  logic RESET   = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  q8[$];
  logic [63:0] q64[$];

  burst_read_buffer_if #(.WIDTH(32), .DEPTH(8))  m_if ();
  burst_read_buffer_if #(.WIDTH(8),  .DEPTH(2))  s8_if ();
  burst_read_buffer_if #(.WIDTH(64), .DEPTH(16)) s64_if ();

  burst_read_buffer #(.WIDTH(32), .DEPTH(8)) u_dut (
    .DRAMCLK(DRAMCLK), .RESET(RESET), .bus(m_if)
  );
  burst_read_buffer #(.WIDTH(8), .DEPTH(2)) u_dut8 (
    .DRAMCLK(DRAMCLK), .RESET(RESET), .bus(s8_if)
  );
  burst_read_buffer #(.WIDTH(64), .DEPTH(16)) u_dut64 (
    .DRAMCLK(DRAMCLK), .RESET(RESET), .bus(s64_if)
  );

  always #5 DRAMCLK = ~DRAMCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge DRAMCLK);
    #1;
  endtask

  task automatic m_drive(input logic we, input logic start, input logic ack,
                         input logic [31:0] d);
    m_if.WE = we; m_if.START = start; m_if.LINE_ACK = ack; m_if.dIn = d;
    tick();
    m_if.WE = 1'b0; m_if.START = 1'b0; m_if.LINE_ACK = 1'b0;
  endtask

  task automatic s_drive(input logic we, input logic start, input logic ack,
                         input logic [7:0] d8, input logic [63:0] d64);
    s8_if.WE  = we; s8_if.START  = start; s8_if.LINE_ACK  = ack; s8_if.dIn  = d8;
    s64_if.WE = we; s64_if.START = start; s64_if.LINE_ACK = ack; s64_if.dIn = d64;
    tick();
    s8_if.WE  = 1'b0; s8_if.START  = 1'b0; s8_if.LINE_ACK  = 1'b0;
    s64_if.WE = 1'b0; s64_if.START = 1'b0; s64_if.LINE_ACK = 1'b0;
  endtask

  // START, then eight consecutive words base..base+7, each pushed to the scoreboard.
  task automatic m_fill(input logic [31:0] base);
    m_drive(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(base + 32'(i));
      m_drive(1'b1, 1'b0, 1'b0, base + 32'(i));
    end
  endtask

  function automatic logic [255:0] line_of(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic test_reset();
    #1;
    n_tests++; if (m_if.dOut !== '0) begin n_fail++; $display("FAIL reset_dout: got %0h want 0", m_if.dOut); end
    n_tests++; if (m_if.COUNT !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", m_if.COUNT); end
    n_tests++; if ({m_if.LINE_VALID, m_if.BUSY, m_if.OVERFLOW} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {m_if.LINE_VALID, m_if.BUSY, m_if.OVERFLOW});
    end
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_idle_ignore();
    m_drive(1'b1, 1'b0, 1'b0, 32'hBEEF);
    m_drive(1'b1, 1'b0, 1'b1, 32'hBEEF);
    n_tests++; if (m_if.COUNT !== 4'd0) begin n_fail++; $display("FAIL idle_we_count: got %0d want 0", m_if.COUNT); end
    n_tests++; if ({m_if.LINE_VALID, m_if.BUSY, m_if.OVERFLOW} !== 3'b000) begin
      n_fail++; $display("FAIL idle_we_flags: got %b want 000", {m_if.LINE_VALID, m_if.BUSY, m_if.OVERFLOW});
    end
    n_tests++; if (m_if.dOut !== '0) begin n_fail++; $display("FAIL idle_we_noshift: got %0h want 0", m_if.dOut); end
  endtask

  task automatic test_fill_ack();
    logic [31:0] e;
    m_drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++; if (m_if.BUSY !== 1'b1 || m_if.COUNT !== 4'd0) begin
      n_fail++; $display("FAIL fill_start: got busy=%b count=%0d want busy=1 count=0", m_if.BUSY, m_if.COUNT);
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'h10 + 32'(i));
      m_drive(1'b1, 1'b0, 1'b0, 32'h10 + 32'(i));
      n_tests++; if (m_if.COUNT !== 4'(i + 1)) begin
        n_fail++; $display("FAIL fill_count: got %0d want %0d", m_if.COUNT, i + 1);
      end
    end
    n_tests++; if (m_if.LINE_VALID !== 1'b1 || m_if.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL fill_valid: got valid=%b busy=%b want 1/0", m_if.LINE_VALID, m_if.BUSY);
    end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      n_tests++; if (m_if.dOut[i*32 +: 32] !== e) begin
        n_fail++; $display("FAIL fill_slot%0d: got %0h want %0h", i, m_if.dOut[i*32 +: 32], e);
      end
    end
    m_drive(1'b0, 1'b0, 1'b1, 32'h0);
    n_tests++; if (m_if.LINE_VALID !== 1'b0 || m_if.COUNT !== 4'd0 || m_if.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL fill_ack: got valid=%b count=%0d busy=%b want 0/0/0",
                         m_if.LINE_VALID, m_if.COUNT, m_if.BUSY);
    end
  endtask

  task automatic test_gapped();
    logic [31:0] e;
    int gaps;
    m_drive(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      gaps = $urandom_range(1, 3);
      for (int g = 0; g < gaps; g++) begin
        // LINE_ACK during a fill must be ignored
        m_drive(1'b0, 1'b0, (g == 0), 32'hFFFF);
        n_tests++; if (m_if.BUSY !== 1'b1 || m_if.COUNT !== 4'(i)) begin
          n_fail++; $display("FAIL gap_busy: got busy=%b count=%0d want 1/%0d", m_if.BUSY, m_if.COUNT, i);
        end
      end
      exp_q.push_back(32'h10 + 32'(i));
      m_drive(1'b1, 1'b0, 1'b0, 32'h10 + 32'(i));
    end
    n_tests++; if (m_if.LINE_VALID !== 1'b1 || m_if.COUNT !== 4'd8) begin
      n_fail++; $display("FAIL gap_valid: got valid=%b count=%0d want 1/8", m_if.LINE_VALID, m_if.COUNT);
    end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      n_tests++; if (m_if.dOut[i*32 +: 32] !== e) begin
        n_fail++; $display("FAIL gap_slot%0d: got %0h want %0h", i, m_if.dOut[i*32 +: 32], e);
      end
    end
    m_drive(1'b0, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic test_overflow();
    logic [31:0] e;
    m_fill(32'h10);
    n_tests++; if (m_if.LINE_VALID !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", m_if.LINE_VALID); end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      n_tests++; if (m_if.dOut[i*32 +: 32] !== e) begin
        n_fail++; $display("FAIL ovf_slot%0d: got %0h want %0h", i, m_if.dOut[i*32 +: 32], e);
      end
    end
    m_drive(1'b1, 1'b0, 1'b0, 32'hDEAD);
    n_tests++; if (m_if.OVERFLOW !== 1'b1 || m_if.COUNT !== 4'd8) begin
      n_fail++; $display("FAIL ovf_flag: got ovf=%b count=%0d want 1/8", m_if.OVERFLOW, m_if.COUNT);
    end
    n_tests++; if (m_if.dOut !== line_of(32'h10)) begin
      n_fail++; $display("FAIL ovf_hold: got %0h want %0h", m_if.dOut, line_of(32'h10));
    end
    m_drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++; if (m_if.LINE_VALID !== 1'b1 || m_if.OVERFLOW !== 1'b1) begin
      n_fail++; $display("FAIL full_start_ignored: got valid=%b ovf=%b want 1/1", m_if.LINE_VALID, m_if.OVERFLOW);
    end
    m_drive(1'b0, 1'b0, 1'b1, 32'h0);
    n_tests++; if (m_if.OVERFLOW !== 1'b1 || m_if.LINE_VALID !== 1'b0) begin
      n_fail++; $display("FAIL ovf_sticky: got ovf=%b valid=%b want 1/0", m_if.OVERFLOW, m_if.LINE_VALID);
    end
    m_drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_tests++; if (m_if.OVERFLOW !== 1'b0 || m_if.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL ovf_clear: got ovf=%b busy=%b want 0/1", m_if.OVERFLOW, m_if.BUSY);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    m_fill(32'h30);
    exp_q.delete();
    m_drive(1'b1, 1'b0, 1'b0, 32'hDEAD);
    exp_q.push_back(32'h20);
    m_drive(1'b1, 1'b1, 1'b1, 32'h20);
    n_tests++; if (m_if.BUSY !== 1'b1 || m_if.COUNT !== 4'd1 || m_if.OVERFLOW !== 1'b0 || m_if.LINE_VALID !== 1'b0) begin
      n_fail++; $display("FAIL b2b_switch: got busy=%b count=%0d ovf=%b valid=%b want 1/1/0/0",
                         m_if.BUSY, m_if.COUNT, m_if.OVERFLOW, m_if.LINE_VALID);
    end
    for (int i = 1; i < 8; i++) begin
      exp_q.push_back(32'h20 + 32'(i));
      m_drive(1'b1, 1'b0, 1'b0, 32'h20 + 32'(i));
    end
    n_tests++; if (m_if.LINE_VALID !== 1'b1 || m_if.COUNT !== 4'd8) begin
      n_fail++; $display("FAIL b2b_valid: got valid=%b count=%0d want 1/8", m_if.LINE_VALID, m_if.COUNT);
    end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      n_tests++; if (m_if.dOut[i*32 +: 32] !== e) begin
        n_fail++; $display("FAIL b2b_slot%0d: got %0h want %0h", i, m_if.dOut[i*32 +: 32], e);
      end
    end
    m_drive(1'b0, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic test_restart();
    logic [31:0] e;
    m_drive(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) m_drive(1'b1, 1'b0, 1'b0, 32'h40 + 32'(i));
    exp_q.push_back(32'h50);
    m_drive(1'b1, 1'b1, 1'b0, 32'h50);
    n_tests++; if (m_if.COUNT !== 4'd1 || m_if.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL restart_count: got count=%0d busy=%b want 1/1", m_if.COUNT, m_if.BUSY);
    end
    for (int i = 1; i < 8; i++) begin
      exp_q.push_back(32'h50 + 32'(i));
      m_drive(1'b1, 1'b0, 1'b0, 32'h50 + 32'(i));
    end
    n_tests++; if (m_if.LINE_VALID !== 1'b1) begin n_fail++; $display("FAIL restart_valid: got %b want 1", m_if.LINE_VALID); end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      n_tests++; if (m_if.dOut[i*32 +: 32] !== e) begin
        n_fail++; $display("FAIL restart_slot%0d: got %0h want %0h", i, m_if.dOut[i*32 +: 32], e);
      end
    end
    m_drive(1'b0, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic test_async_reset();
    m_drive(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) m_drive(1'b1, 1'b0, 1'b0, 32'h60 + 32'(i));
    #2;
    RESET = 1'b1;
    #1;
    n_tests++; if (m_if.dOut !== '0 || m_if.COUNT !== 4'd0) begin
      n_fail++; $display("FAIL areset_data: got dout=%0h count=%0d want 0/0", m_if.dOut, m_if.COUNT);
    end
    n_tests++; if ({m_if.LINE_VALID, m_if.BUSY, m_if.OVERFLOW} !== 3'b000) begin
      n_fail++; $display("FAIL areset_flags: got %b want 000", {m_if.LINE_VALID, m_if.BUSY, m_if.OVERFLOW});
    end
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_drive(1'b1, 1'b0, 1'b0, 32'h70 + 32'(i));
      n_tests++; if (m_if.COUNT !== 4'd0 || m_if.LINE_VALID !== 1'b0 || m_if.BUSY !== 1'b0) begin
        n_fail++; $display("FAIL areset_ignore: got count=%0d valid=%b busy=%b want 0/0/0",
                           m_if.COUNT, m_if.LINE_VALID, m_if.BUSY);
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0]  d8, e8;
    logic [63:0] d64, e64;
    logic [15:0] l8;
    l8 = {8'h41, 8'h40};
    s_drive(1'b0, 1'b1, 1'b0, 8'h0, 64'h0);
    for (int i = 0; i < 16; i++) begin
      d8  = 8'h40 + 8'(i);
      d64 = 64'hC0DE_0000_0000_0000 + 64'(i);
      if (i < 2) q8.push_back(d8);
      q64.push_back(d64);
      s_drive(1'b1, 1'b0, 1'b0, d8, d64);
      if (i == 1) begin
        n_tests++; if (s8_if.LINE_VALID !== 1'b1 || s8_if.COUNT !== 2'd2) begin
          n_fail++; $display("FAIL s8_valid: got valid=%b count=%0d want 1/2", s8_if.LINE_VALID, s8_if.COUNT);
        end
        for (int k = 0; k < 2; k++) begin
          e8 = q8.pop_front();
          n_tests++; if (s8_if.dOut[k*8 +: 8] !== e8) begin
            n_fail++; $display("FAIL s8_slot%0d: got %0h want %0h", k, s8_if.dOut[k*8 +: 8], e8);
          end
        end
      end
      if (i >= 2) begin
        n_tests++; if (s8_if.COUNT !== 2'd2 || s8_if.OVERFLOW !== 1'b1 || s8_if.dOut !== l8) begin
          n_fail++; $display("FAIL s8_overflow: got count=%0d ovf=%b dout=%0h want 2/1/%0h",
                             s8_if.COUNT, s8_if.OVERFLOW, s8_if.dOut, l8);
        end
      end
      if (i < 15) begin
        n_tests++; if (s64_if.BUSY !== 1'b1 || s64_if.COUNT !== 5'(i + 1)) begin
          n_fail++; $display("FAIL s64_fill: got busy=%b count=%0d want 1/%0d", s64_if.BUSY, s64_if.COUNT, i + 1);
        end
      end
    end
    n_tests++; if (s64_if.LINE_VALID !== 1'b1 || s64_if.COUNT !== 5'd16) begin
      n_fail++; $display("FAIL s64_valid: got valid=%b count=%0d want 1/16", s64_if.LINE_VALID, s64_if.COUNT);
    end
    for (int k = 0; k < 16; k++) begin
      e64 = q64.pop_front();
      n_tests++; if (s64_if.dOut[k*64 +: 64] !== e64) begin
        n_fail++; $display("FAIL s64_slot%0d: got %0h want %0h", k, s64_if.dOut[k*64 +: 64], e64);
      end
    end
    s_drive(1'b1, 1'b0, 1'b0, 8'hFF, 64'hDEAD);
    n_tests++; if (s64_if.OVERFLOW !== 1'b1 || s64_if.COUNT !== 5'd16) begin
      n_fail++; $display("FAIL s64_overflow: got ovf=%b count=%0d want 1/16", s64_if.OVERFLOW, s64_if.COUNT);
    end
    s_drive(1'b0, 1'b0, 1'b1, 8'h0, 64'h0);
    n_tests++; if (s8_if.COUNT !== 2'd0 || s64_if.COUNT !== 5'd0 || s8_if.LINE_VALID !== 1'b0 || s64_if.LINE_VALID !== 1'b0) begin
      n_fail++; $display("FAIL sweep_ack: got count8=%0d count64=%0d want 0/0", s8_if.COUNT, s64_if.COUNT);
    end
    s_drive(1'b0, 1'b1, 1'b0, 8'h0, 64'h0);
    n_tests++; if (s8_if.OVERFLOW !== 1'b0 || s64_if.OVERFLOW !== 1'b0) begin
      n_fail++; $display("FAIL sweep_ovf_clear: got ovf8=%b ovf64=%b want 0/0", s8_if.OVERFLOW, s64_if.OVERFLOW);
    end
  endtask

  initial begin
    m_if.WE = 1'b0;   m_if.START = 1'b0;   m_if.LINE_ACK = 1'b0;   m_if.dIn = '0;
    s8_if.WE = 1'b0;  s8_if.START = 1'b0;  s8_if.LINE_ACK = 1'b0;  s8_if.dIn = '0;
    s64_if.WE = 1'b0; s64_if.START = 1'b0; s64_if.LINE_ACK = 1'b0; s64_if.dIn = '0;
    test_reset();
    test_idle_ignore();
    test_fill_ack();
    test_gapped();
    test_overflow();
    test_back_to_back();
    test_restart();
    test_async_reset();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/burst_read_buffer.md
BURST_READ_BUFFER -- requirements
Module: burst_read_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning bits per DRAM word (legal range 1..128).
REQ-002 SHALL have parameter DEPTH, default 8, meaning words per line (legal range 2..64).
REQ-003 SHALL have port DRAMCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port WE, input, 1 bit: a DRAM word is present on dIn this cycle.
REQ-006 SHALL have port dIn, input, WIDTH bits: DRAM read data word.
REQ-007 SHALL have port START, input, 1 bit: begin a new burst; clears the word count.
REQ-008 SHALL have port LINE_ACK, input, 1 bit: the consumer accepts the assembled line.
REQ-009 SHALL have port dOut, output, WIDTH*DEPTH bits: the assembled line.
REQ-010 SHALL have port LINE_VALID, output, 1 bit: dOut holds a complete line.
REQ-011 SHALL have port COUNT, output, clog2(DEPTH+1) bits: number of words captured in the current burst.
REQ-012 SHALL have port BUSY, output, 1 bit: a burst is being filled.
REQ-013 SHALL have port OVERFLOW, output, 1 bit: sticky flag; a word arrived while the line was full.

Function
REQ-014 SHALL implement three states, IDLE, FILL and FULL: BUSY=1 only in FILL, and LINE_VALID=1 only in FULL.
REQ-015 Shift rule: SHALL, on each accepted WE, shift every slot k down to slot k-1 and load dIn into slot DEPTH-1; slot 0 is discarded.
REQ-016 Line ordering: after DEPTH accepted words, the first word received SHALL occupy dOut[WIDTH-1:0] and the last word received SHALL occupy the top slot.
REQ-017 IDLE: SHALL ignore WE (no shift, no COUNT change, no OVERFLOW).
REQ-018 IDLE: START SHALL move the block to FILL with COUNT=0.
REQ-019 FILL: each WE SHALL shift and increment COUNT by 1.
REQ-020 FILL: the WE that makes COUNT reach DEPTH SHALL move the block to FULL on the same edge, so LINE_VALID=1 in the cycle COUNT first reads DEPTH (latency 0 cycles after the edge of the last word).
REQ-021 FULL: dOut and COUNT SHALL hold, and WE SHALL be dropped (no shift) and set OVERFLOW=1.
REQ-022 FULL: LINE_ACK without START SHALL move the block to IDLE, with COUNT=0 and LINE_VALID=0 on the next cycle.
REQ-023 FULL: START without LINE_ACK SHALL be ignored, and the line SHALL remain valid.
REQ-024 FULL: START and LINE_ACK in the same cycle SHALL move the block to FILL with COUNT=0 (back-to-back burst).
REQ-025 FULL: a WE in that same START+LINE_ACK cycle SHALL be captured as word 1, giving COUNT=1, with no OVERFLOW.
REQ-026 START in FILL SHALL restart the burst: COUNT=0, and a simultaneous WE gives COUNT=1 and shifts that word in; stale slot contents are not cleared.
REQ-027 START with WE in IDLE SHALL capture that word as word 1 (COUNT=1, state FILL).
REQ-028 LINE_ACK outside FULL SHALL be ignored.
REQ-029 OVERFLOW SHALL be cleared only by RESET or by an accepted START; if START and an overflowing WE coincide, START wins and OVERFLOW is cleared.
REQ-030 dOut contents SHALL be defined only while LINE_VALID=1; in other states they are free to change but SHALL follow REQ-015.
REQ-031 COUNT SHALL never exceed DEPTH and SHALL never wrap.

Reset
REQ-032 RESET assertion SHALL, immediately and independently of DRAMCLK, force: state IDLE, every dOut slot to 0, COUNT=0, LINE_VALID=0, BUSY=0, OVERFLOW=0.
REQ-033 RESET asserted mid-burst or while FULL SHALL discard the partial or complete line, and no LINE_VALID pulse SHALL follow.
REQ-034 After RESET deasserts, the block SHALL ignore WE until a START is seen.

Verification
REQ-035 Fill and acknowledge (WIDTH=32, DEPTH=8): START, then 8 consecutive WEs with dIn=0x10..0x17 -> LINE_VALID=1 with COUNT=8 after the 8th edge, dOut[31:0]=0x10, dOut[255:224]=0x17; LINE_ACK -> IDLE, COUNT=0.
REQ-036 Gapped fill: START, then 8 WEs separated by random idle cycles -> BUSY=1 throughout, and the same dOut as REQ-035 once LINE_VALID=1.
REQ-037 Overflow: full line, then WE with dIn=0xDEAD -> OVERFLOW=1 and dOut unchanged; a later START -> OVERFLOW=0.
REQ-038 Back-to-back: in FULL, START+LINE_ACK+WE(dIn=0x20) in one cycle -> state FILL, COUNT=1, OVERFLOW=0; 7 more WEs (0x21..0x27) -> dOut[31:0]=0x20.
REQ-039 Async reset: RESET pulsed between clock edges after 5 words -> all outputs 0 immediately; subsequent WEs without START -> COUNT stays 0.
REQ-040 Parameter sweep: WIDTH=8 with DEPTH=2, and WIDTH=64 with DEPTH=16, each run through REQ-035 and REQ-037 -> correct word ordering and COUNT bound equal to DEPTH.
